// File: rtl/scarv_cop_mem_arbiter.sv
// scarv_cop_mem_arbiter
//   Shares one pipelined cen/stall memory port between the host CPU data port
//   and the COP memory port. The request mux is combinational, so no cycles
//   are added. Responses (stall/rdata/error) are routed only by the registered
//   owner of the outstanding data phase.
//
// Parameters
//   ARB_MODE  0: CPU fixed priority, 1: COP fixed priority, 2: round robin
//
// Ports
//   g_clk, g_reset            clock, synchronous active-high reset
//   cpu_mem_*                 CPU master: cen/wen/addr/wdata/ben in,
//                             rdata/stall/error out
//   cop_mem_*                 COP master, same set of signals as the CPU
//   ram_cen/wen/addr/wdata/ben  shared request out
//   ram_rdata/stall/error     shared response in
module scarv_cop_mem_arbiter #(
    parameter int ARB_MODE = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        cpu_mem_cen,
    input  logic        cpu_mem_wen,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_ben,
    output logic [31:0] cpu_mem_rdata,
    output logic        cpu_mem_stall,
    output logic        cpu_mem_error,

    input  logic        cop_mem_cen,
    input  logic        cop_mem_wen,
    input  logic [31:0] cop_mem_addr,
    input  logic [31:0] cop_mem_wdata,
    input  logic [3:0]  cop_mem_ben,
    output logic [31:0] cop_mem_rdata,
    output logic        cop_mem_stall,
    output logic        cop_mem_error,

    output logic        ram_cen,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_ben,
    input  logic [31:0] ram_rdata,
    input  logic        ram_stall,
    input  logic        ram_error
);

    logic        dp_valid;   // data phase outstanding on the ram port
    logic        dp_own;     // owner of that data phase: 0=CPU, 1=COP
    logic        sel_q;      // previous cycle's mux select
    logic        rr_last;    // last granted master
    logic        cpu_pend;   // CPU requested last cycle and was not accepted
    logic        cop_pend;

    logic        bus_free;
    logic        arb_sel;
    logic        sel;
    logic        accept;
    logic [31:0] addr_mux;

    assign bus_free = !dp_valid || !ram_stall;

    always_comb begin
        arb_sel = sel_q;
        if (cpu_mem_cen && cop_mem_cen) begin
            if (ARB_MODE == 0)      arb_sel = 1'b0;
            else if (ARB_MODE == 1) arb_sel = 1'b1;
            else                    arb_sel = !rr_last;
        end else if (cpu_mem_cen) begin
            arb_sel = 1'b0;
        end else if (cop_mem_cen) begin
            arb_sel = 1'b1;
        end
    end

    // While the current data phase is stalled the pending address on the
    // ram port must not move, so the mux is frozen.
    assign sel = bus_free ? arb_sel : sel_q;

    assign addr_mux  = sel ? cop_mem_addr  : cpu_mem_addr;
    assign ram_cen   = (sel ? cop_mem_cen : cpu_mem_cen) && !g_reset;
    assign ram_wen   = sel ? cop_mem_wen   : cpu_mem_wen;
    assign ram_wdata = sel ? cop_mem_wdata : cpu_mem_wdata;
    assign ram_ben   = sel ? cop_mem_ben   : cpu_mem_ben;
    assign ram_addr  = addr_mux & 32'hFFFF_FFFC;

    assign accept = ram_cen && bus_free;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            dp_valid <= 1'b0;
            dp_own   <= 1'b0;
            sel_q    <= 1'b0;
            rr_last  <= 1'b1;   // CPU wins the first round-robin contest
            cpu_pend <= 1'b0;
            cop_pend <= 1'b0;
        end else begin
            sel_q <= sel;
            if (accept) begin
                dp_valid <= 1'b1;
                dp_own   <= sel;
                rr_last  <= sel;
            end else if (dp_valid && !ram_stall) begin
                dp_valid <= 1'b0;
            end
            // A losing master sees stall=1 next cycle so it keeps cen held.
            cpu_pend <= cpu_mem_cen && !(accept && !sel);
            cop_pend <= cop_mem_cen && !(accept &&  sel);
        end
    end

    always_comb begin
        cpu_mem_stall = cpu_pend;
        cpu_mem_rdata = 32'h0;
        cpu_mem_error = 1'b0;
        cop_mem_stall = cop_pend;
        cop_mem_rdata = 32'h0;
        cop_mem_error = 1'b0;
        if (g_reset) begin
            cpu_mem_stall = 1'b1;
            cop_mem_stall = 1'b1;
        end else if (dp_valid) begin
            if (dp_own) begin
                cop_mem_stall = ram_stall;
                cop_mem_rdata = ram_rdata;
                cop_mem_error = ram_error && !ram_stall;
            end else begin
                cpu_mem_stall = ram_stall;
                cpu_mem_rdata = ram_rdata;
                cpu_mem_error = ram_error && !ram_stall;
            end
        end
    end

endmodule
